// File: rtl/mem_access_unit.sv
// Load/store sequencer for a 64-bit doubleword-wide data memory: lane extract/extend on loads,
// read-modify-write for sub-doubleword stores. Define MAU_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        write,
    input  logic [1:0]  tam,
    input  logic        unsigned_ld,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [63:0] mem_addr,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StDone, StErr} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [1:0]  tam_q;
    logic        uns_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;

    logic [2:0]  align_mask;
    logic        req_mis;
    logic [63:0] addr_in;
    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] ext;
    logic [63:0] lane_mask;
    logic [63:0] merged;

    // Low address bits that must be zero for a naturally aligned access of this width.
    always_comb begin
        unique case (tam)
            2'b00:   align_mask = 3'b111;
            2'b01:   align_mask = 3'b011;
            2'b10:   align_mask = 3'b001;
            default: align_mask = 3'b000;
        endcase
    end

`ifdef MAU_MISALIGN_TRAP_EN
    assign req_mis    = |(addr[2:0] & align_mask);
    assign addr_in    = addr;
    assign misaligned = (state_q == StErr);
`else
    assign req_mis    = 1'b0;
    assign addr_in    = {addr[63:3], addr[2:0] & ~align_mask};
    assign misaligned = 1'b0;
`endif

    assign shamt   = {addr_q[2:0], 3'b000};
    assign shifted = mem_rdata >> shamt;

    always_comb begin
        unique case (tam_q)
            2'b00: begin
                ext       = shifted;
                lane_mask = {64{1'b1}};
            end
            2'b01: begin
                ext       = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
                lane_mask = 64'h0000_0000_FFFF_FFFF;
            end
            2'b10: begin
                ext       = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
                lane_mask = 64'h0000_0000_0000_FFFF;
            end
            default: begin
                ext       = {{56{~uns_q & shifted[7]}}, shifted[7:0]};
                lane_mask = 64'h0000_0000_0000_00FF;
            end
        endcase
    end

    assign merged = (mem_rdata & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (req_mis) begin
                        state_d = StErr;
                    end else if (write && tam == 2'b00) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                        cnt_d   = 2'(READ_LAT - 1);
                    end
                end
            end
            StRead: begin
                if (cnt_q == 2'd0) begin
                    state_d = write_q ? StWrite : StDone;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 2'd0;
            write_q   <= 1'b0;
            tam_q     <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            rdata     <= 64'd0;
            mem_wdata <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && start) begin
                write_q   <= write;
                tam_q     <= tam;
                uns_q     <= unsigned_ld;
                addr_q    <= addr_in;
                wdata_q   <= wdata;
                // Full-width stores skip the read, so the word must be ready on entry to WRITE.
                mem_wdata <= wdata;
            end
            if (state_q == StRead && cnt_q == 2'd0) begin
                if (write_q) begin
                    mem_wdata <= merged;
                end else begin
                    rdata <= ext;
                end
            end
        end
    end

    assign mem_addr = {addr_q[63:3], 3'b000};
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone) || (state_q == StErr);
    assign mem_wr   = (state_q == StWrite);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit against a byte-level model of loads, stores and timing.
module tb_mem_access_unit;
    localparam int unsigned READ_LAT = 1;

    logic        clk = 1'b0;
    logic        reset, start, write, unsigned_ld;
    logic [1:0]  tam;
    logic [63:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic        busy, done, misaligned, mem_wr;
    logic        mem_load;

    logic [63:0] mem     [256];
    logic [63:0] ref_mem [256];
    logic [63:0] exp_rdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_access_unit #(.READ_LAT(READ_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .write      (write),
        .tam        (tam),
        .unsigned_ld(unsigned_ld),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr[63:11] == 53'd0) ? mem[mem_addr[10:3]] : 64'd0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_wr) begin
            mem[mem_addr[10:3]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered and left at a falling edge with the DUT idle; leaves start low.
    task automatic run_tx(input logic w, input logic [1:0] t, input logic u,
                          input logic [63:0] a, input logic [63:0] d);
        int          size, off, lat, idx;
        logic        trap;
        logic [63:0] ea, word, res, nw;
        size = 8 >> t;
`ifdef MAU_MISALIGN_TRAP_EN
        trap = (a % size) != 0;
`else
        trap = 1'b0;
`endif
        ea   = a - (a % size);
        off  = int'(ea % 8);
        idx  = int'(ea[10:3]);
        word = ref_mem[idx];
        res  = 64'd0;
        nw   = word;
        for (int i = 0; i < size; i++) begin
            res[8*i +: 8]       = word[8*(off+i) +: 8];
            nw[8*(off+i) +: 8]  = d[8*i +: 8];
        end
        if (size < 8 && !u && res[8*size-1])
            for (int i = size; i < 8; i++) res[8*i +: 8] = 8'hFF;
        if (trap)         lat = 1;
        else if (!w)      lat = READ_LAT + 1;
        else if (size == 8) lat = 2;
        else              lat = READ_LAT + 2;

        write = w; tam = t; unsigned_ld = u; addr = a; wdata = d; start = 1'b1;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k <= lat) begin
                check("busy", busy, 1);
                check("done", done, k == lat);
                check("mem_wr", mem_wr, w && !trap && k == lat - 1);
                check("misaligned", misaligned, trap && k == lat);
                check("mem_addr", mem_addr, {ea[63:3], 3'b000});
                if (w && !trap && k == lat - 1) check("mem_wdata", mem_wdata, nw);
                if (k == lat && !w && !trap) exp_rdata = res;
                check("rdata", rdata, exp_rdata);
                // Requests presented while busy must be ignored.
                start = 1'($urandom_range(0, 1));
                write = 1'($urandom_range(0, 1));
                tam   = 2'($urandom_range(0, 3));
                addr  = 64'h100 + 64'($urandom_range(0, 127));
                wdata = {$urandom, $urandom};
            end else begin
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_mem_wr", mem_wr, 0);
                start = 1'b0;
            end
        end
        if (w && !trap) ref_mem[idx] = nw;
        check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        reset = 1'b1; mem_load = 1'b1; start = 1'b0; write = 1'b0; tam = 2'b00;
        unsigned_ld = 1'b0; addr = 64'd0; wdata = 64'd0; exp_rdata = 64'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = {$urandom, $urandom};
        ref_mem[32] = 64'h1122334455667788;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_misaligned", misaligned, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0; mem_load = 1'b0;
        @(negedge clk);

        run_tx(1'b0, 2'b11, 1'b0, 64'h100, 64'd0);
        check("lb_100", rdata, 64'hFFFF_FFFF_FFFF_FF88);
        run_tx(1'b0, 2'b11, 1'b1, 64'h100, 64'd0);
        check("lbu_100", rdata, 64'h0000_0000_0000_0088);
        run_tx(1'b0, 2'b11, 1'b0, 64'h107, 64'd0);
        check("lb_107", rdata, 64'h0000_0000_0000_0011);
        run_tx(1'b0, 2'b01, 1'b0, 64'h104, 64'd0);
        check("lw_104", rdata, 64'h0000_0000_1122_3344);
        run_tx(1'b1, 2'b10, 1'b0, 64'h102, 64'h0000_0000_0000_ABCD);
        check("sh_102", mem[32], 64'h1122_3344_ABCD_7788);
        run_tx(1'b1, 2'b01, 1'b0, 64'h101, 64'h0000_0000_CAFE_F00D);
`ifdef MAU_MISALIGN_TRAP_EN
        check("sw_101", mem[32], 64'h1122_3344_ABCD_7788);
`else
        check("sw_101", mem[32], 64'h1122_3344_CAFE_F00D);
`endif
        run_tx(1'b1, 2'b00, 1'b0, 64'h100, 64'hDEAD_BEEF_0000_0001);
        check("sd_100", mem[32], 64'hDEAD_BEEF_0000_0001);

        // Reset during the READ of a halfword store abandons the write.
        write = 1'b1; tam = 2'b10; unsigned_ld = 1'b0; addr = 64'h102; wdata = 64'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rmw_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mem_wr", mem_wr, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = 64'd0;
        repeat (2) @(negedge clk);
        check("rst_mid_mem", mem[32], 64'hDEAD_BEEF_0000_0001);
        check("rst_mid_rdata", rdata, 0);

        for (int n = 0; n < 300; n++) begin
            run_tx(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 64'h100 + 64'($urandom_range(0, 127)),
                   {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
